ring_rr_scheduler: RTL and testbench

RING_RR_SCHEDULER -- requirements
Module: ring_rr_scheduler

---
 rtl/ring_sched_pkg.sv | 36 +++
 rtl/ring_pick.sv | 36 +++
 rtl/ring_rr_scheduler_props.sv | 47 ++++
 rtl/ring_rr_scheduler.sv | 106 ++++++++++
 tb/tb_ring_rr_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_sched_pkg.sv
// ring_sched_pkg
//   Shared types and constants for the ring round-robin scheduler:
//   the two-state FSM encoding, the number of requesters, the pointer
//   value loaded at reset, and small helpers for ring rotation and
//   one-hot-to-index conversion.
package ring_sched_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int HOLD_W = 8;

  localparam logic [N_REQ-1:0] PTR_RST = 4'b0001;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Ring order is a right rotation: 0001 -> 1000 -> 0100 -> 0010 -> 0001.
  function automatic logic [N_REQ-1:0] rot_right(input logic [N_REQ-1:0] v);
    return {v[0], v[N_REQ-1:1]};
  endfunction

  // Index of the set bit in a one-hot vector; a non-one-hot value maps to 0.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ring_pick.sv
// ring_pick
//   Combinational rotate-priority search. Starting at the bit set in ptr
//   and walking the ring in right-rotate order (index decreasing, wrapping
//   3 -> 2 -> 1 -> 0 -> 3), the first set req bit wins.
//   Ports:
//     ptr    - one-hot priority pointer
//     req    - request vector
//     winner - one-hot winner, 0 when req is 0
module ring_pick
  import ring_sched_pkg::*;
(
  input  logic [N_REQ-1:0] ptr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] winner
);

  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    winner    = '0;
    found     = 1'b0;
    start_idx = onehot_idx(ptr);
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Index subtraction wraps modulo N_REQ through the 2-bit width.
      idx = start_idx - IDX_W'(k);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_rr_scheduler_props.sv
// ring_rr_scheduler_props
//   Property checks bound into ring_rr_scheduler: grant is one-hot or
//   zero and zero whenever idle, a grant never switches directly to a
//   different requester, and timeout only follows a hold-limit revoke.
//   Ports:
//     clk, rst            - scheduler clock and active-low reset
//     req, done           - scheduler inputs
//     grant, busy, timeout- scheduler outputs
//     at_limit            - hold counter at MAX_HOLD-1
module ring_rr_scheduler_props
  import ring_sched_pkg::*;
(
  input logic             clk,
  input logic             rst,
  input logic [N_REQ-1:0] req,
  input logic             done,
  input logic [N_REQ-1:0] grant,
  input logic             busy,
  input logic             timeout,
  input logic             at_limit
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant));

  a_idle_no_grant: assert property (@(posedge clk) disable iff (!rst)
    !busy |-> (grant == '0));

  a_turnaround: assert property (@(posedge clk) disable iff (!rst)
    (grant != '0) |=> ((grant == '0) || (grant == $past(grant))));

  a_timeout_cause: assert property (@(posedge clk) disable iff (!rst)
    timeout |-> ((grant == '0) && ($past(grant) != '0) && $past(at_limit) &&
                 !$past(done) && ($past(req & grant) != '0)));

endmodule

bind ring_rr_scheduler ring_rr_scheduler_props u_props (
  .clk      (clk),
  .rst      (rst),
  .req      (req),
  .done     (done),
  .grant    (grant),
  .busy     (busy),
  .timeout  (timeout),
  .at_limit (at_limit)
);

// File: rtl/ring_rr_scheduler.sv
// ring_rr_scheduler
//   Four-requester round-robin scheduler with a ring priority pointer,
//   a bounded hold time and a mandatory idle cycle between grants.
//   Ports:
//     clk     - clock, all state updates on posedge
//     rst     - asynchronous active-low reset
//     enable  - allows a new grant to be issued from IDLE
//     req     - level-sensitive per-requester requests
//     done    - current grantee finished (only looked at in GRANT)
//     grant   - registered one-hot grant, 0 when idle
//     ptr     - registered one-hot ring priority pointer
//     busy    - high while in GRANT
//     timeout - one-cycle pulse when a grant is revoked by MAX_HOLD
module ring_rr_scheduler
  import ring_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ptr,
  output logic             busy,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;

  logic [N_REQ-1:0]    winner;
  logic                withdrawn;
  logic                at_limit;

  ring_pick u_pick (
    .ptr    (ptr_q),
    .req    (req),
    .winner (winner)
  );

  assign withdrawn = ((req & grant_q) == '0);
  assign at_limit  = (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (|req)) begin
          grant_d = winner;
          state_d = GRANT;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (done || withdrawn || at_limit) begin
          grant_d   = '0;
          state_d   = IDLE;
          // The winner drops to lowest priority for the next search.
          ptr_d     = rot_right(grant_q);
          hold_d    = '0;
          // done or withdrawal outranks the hold limit as end cause.
          timeout_d = at_limit && !done && !withdrawn;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PTR_RST;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign ptr     = ptr_q;
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_rr_scheduler.sv
module tb_ring_rr_scheduler;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       done;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] ptr;
  logic       busy;
  logic       timeout;

  ring_rr_scheduler #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .ptr     (ptr),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] ptr;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] seen_q[$];
  logic [3:0] prev_grant;
  string      phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: indices into the 4-bit ring.
  bit         m_busy;
  bit         m_to;
  logic [1:0] m_gidx;
  logic [1:0] m_pidx;
  int         m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: observed %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick(input logic [3:0] rq, input logic [1:0] p);
    logic [1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = p - 2'(k);
      if (rq[idx]) return idx;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_to   = 1'b0;
    m_gidx = 2'd0;
    m_pidx = 2'd0;
    m_hold = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] rq, input bit dn);
    bit dropped;
    if (!m_busy) begin
      m_to = 1'b0;
      if (en && rq != 4'b0000) begin
        m_gidx = pick(rq, m_pidx);
        m_busy = 1'b1;
        m_hold = 0;
      end
    end else begin
      dropped = !rq[m_gidx];
      if (dn || dropped || m_hold == MH - 1) begin
        m_to   = !dn && !dropped;
        m_busy = 1'b0;
        m_pidx = m_gidx - 2'd1;
        m_hold = 0;
      end else begin
        m_hold++;
        m_to = 1'b0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant   = m_busy ? (4'b0001 << m_gidx) : 4'b0000;
    e.ptr     = 4'b0001 << m_pidx;
    e.busy    = m_busy;
    e.timeout = m_to;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the model's prediction, compare after the edge.
  task automatic cycle(input bit en, input logic [3:0] rq, input bit dn);
    exp_t e;
    enable = en;
    req    = rq;
    done   = dn;
    model_step(en, rq, dn);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("grant",   32'(grant),   32'(e.grant));
    chk("ptr",     32'(ptr),     32'(e.ptr));
    chk("busy",    32'(busy),    32'(e.busy));
    chk("timeout", 32'(timeout), 32'(e.timeout));
    if (grant != 4'b0000 && prev_grant == 4'b0000) seen_q.push_back(grant);
    prev_grant = grant;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_grant",   32'(grant),   32'h0);
    chk("rst_ptr",     32'(ptr),     32'h1);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rr_exp [5];
    int         hold_cnt;

    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b1000; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b0010; rr_exp[4] = 4'b0001;

    phase      = "reset";
    rst        = 1'b1;
    enable     = 1'b1;
    req        = 4'b1111;
    done       = 1'b0;
    prev_grant = 4'b0000;
    model_reset();
    #1 rst = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    rst = 1'b1;

    // Round robin: done on the second cycle of every grant.
    phase = "rr";
    seen_q.delete();
    cycle(1'b1, 4'b1111, 1'b0);
    chk("first_grant", 32'(grant), 32'h1);
    for (int g = 0; g < 5; g++) begin
      cycle(1'b1, 4'b1111, 1'b0);
      cycle(1'b1, 4'b1111, 1'b1);
      if (g < 4) cycle(1'b1, 4'b1111, 1'b0);
    end
    chk("rr_count", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++)
      chk($sformatf("rr_seq%0d", i), 32'(seen_q[i]), 32'(rr_exp[i]));

    // Hold limit: grant held for MAX_HOLD cycles, then timeout.
    phase = "timeout";
    cycle(1'b1, 4'b0100, 1'b0);
    hold_cnt = (grant == 4'b0100) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 4'b0100, 1'b0);
      if (grant == 4'b0100) hold_cnt++;
      else break;
    end
    chk("hold_cycles", 32'(hold_cnt), 32'd4);
    chk("to_pulse",    32'(timeout),  32'h1);
    chk("to_grant",    32'(grant),    32'h0);
    chk("to_ptr",      32'(ptr),      32'h2);
    cycle(1'b1, 4'b0000, 1'b0);
    chk("to_single",   32'(timeout),  32'h0);

    // done arriving on the hold-limit cycle ends without timeout.
    phase = "simul";
    cycle(1'b1, 4'b0010, 1'b0);
    repeat (3) cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b1, 4'b0010, 1'b1);
    chk("sim_grant",   32'(grant),   32'h0);
    chk("sim_timeout", 32'(timeout), 32'h0);
    cycle(1'b1, 4'b0000, 1'b0);

    // Withdrawal mid-grant.
    phase = "withdraw";
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b0000, 1'b0);
    chk("wd_grant", 32'(grant), 32'h0);

    // enable low during a grant does not revoke it and blocks the next.
    phase = "enable";
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    chk("en_hold", 32'(grant), 32'h1);
    cycle(1'b0, 4'b1111, 1'b1);
    repeat (3) cycle(1'b0, 4'b1111, 1'b0);
    chk("en_blocked", 32'(busy), 32'h0);
    cycle(1'b1, 4'b1111, 1'b0);
    chk("en_resume", 32'(grant), 32'h8);

    // Asynchronous reset between edges while grant=1000.
    phase = "midrst";
    #3 rst = 1'b0;
    #1 chk_reset_outputs();
    model_reset();
    sb_q.delete();
    prev_grant = 4'b0000;
    @(posedge clk);
    #1 chk_reset_outputs();
    rst = 1'b1;
    cycle(1'b1, 4'b0110, 1'b0);
    chk("post_rst", 32'(grant), 32'h4);

    // Mixed traffic against the model.
    phase = "random";
    for (int i = 0; i < 60; i++)
      cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
